e_calc_pow: RTL

Fixed-point exponentiation engine computing `base^exp` by right-to-left binary square-and-multiply, driven by a runtime exponent. It generalises the fixed squaring-only e-calculation block. It supports:
- parametrised word count and fraction position;
- arbitrary (non-power-of-two) exponents;
- an internal word-serial multiplier;
- overflow detection.

It is the core of the e-approximation path, e.g. (1 + 2^-15)^32768, and is reusable for any unsigned fixed-point power.

---
 rtl/e_calc_pow.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/e_calc_pow.sv
// rtl/e_calc_pow.sv - fixed-point base^exp by right-to-left square-and-multiply
// Word-serial multiplier: one 16 x (16*WORDS) partial product per MUL cycle.
module e_calc_pow #(
    parameter int WORDS      = 32,
    parameter int FRAC_WORDS = 16,
    parameter int EXP_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [16*WORDS-1:0]   base,
    input  logic [EXP_W-1:0]      exp,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   out_data,
    output logic                  overflow
);

    localparam int VW = 16 * WORDS;
    localparam int PW = 32 * WORDS;
    localparam int FB = 16 * FRAC_WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_MUL   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic OP_ACC = 1'b0;
    localparam logic OP_SQ  = 1'b1;

    localparam logic [VW-1:0] ONE = VW'(1) << FB;

    logic [2:0]       state_q, state_d;
    logic [VW-1:0]    acc_q, acc_d;
    logic [VW-1:0]    b_q, b_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic             bit_done_q, bit_done_d;
    logic             op_q, op_d;
    logic             ovf_q, ovf_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [KW-1:0]    k_q, k_d;
    logic [VW-1:0]    out_q, out_d;
    logic             ovf_out_q, ovf_out_d;

    logic [VW-1:0]    mul_a;
    logic [15:0]      m_word;
    logic [VW+15:0]   partial;
    logic [PW-1:0]    pp_shift;
    logic [VW-1:0]    wb_r;
    logic             wb_ovf;
    logic [EXP_W-1:0] e_shift;

    // ACC multiplies acc by b; SQ squares b. The multiplier word always comes from b.
    assign mul_a    = (op_q == OP_ACC) ? acc_q : b_q;
    assign m_word   = b_q[{k_q, 4'b0000} +: 16];
    assign partial  = {16'd0, mul_a} * {{VW{1'b0}}, m_word};
    assign pp_shift = {{(PW - VW - 16){1'b0}}, partial} << {k_q, 4'b0000};
    assign wb_r     = prod_q[FB +: VW];
    assign wb_ovf   = |prod_q[PW-1:FB+VW];
    assign e_shift  = e_q >> 1;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        b_d        = b_q;
        e_d        = e_q;
        bit_done_d = bit_done_q;
        op_d       = op_q;
        ovf_d      = ovf_q;
        prod_d     = prod_q;
        k_d        = k_q;
        out_d      = out_q;
        ovf_out_d  = ovf_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d      = ONE;
                    b_d        = base;
                    e_d        = exp;
                    ovf_d      = 1'b0;
                    bit_done_d = 1'b0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (e_q == '0) begin
                    out_d     = acc_q;
                    ovf_out_d = ovf_q;
                    state_d   = S_DONE;
                end else if (e_q[0] && !bit_done_q) begin
                    op_d       = OP_ACC;
                    bit_done_d = 1'b1;
                    prod_d     = '0;
                    k_d        = '0;
                    state_d    = S_MUL;
                end else begin
                    e_d        = e_shift;
                    bit_done_d = 1'b0;
                    // The square after the top exponent bit is never needed.
                    if (|e_shift) begin
                        op_d    = OP_SQ;
                        prod_d  = '0;
                        k_d     = '0;
                        state_d = S_MUL;
                    end else begin
                        out_d     = acc_q;
                        ovf_out_d = ovf_q;
                        state_d   = S_DONE;
                    end
                end
            end
            S_MUL: begin
                prod_d = prod_q + pp_shift;
                k_d    = k_q + KW'(1);
                if (k_q == KW'(WORDS - 1)) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (op_q == OP_SQ) begin
                    b_d = wb_r;
                end else begin
                    acc_d = wb_r;
                end
                if (wb_ovf) begin
                    ovf_d = 1'b1;
                end
                state_d = S_CHECK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            b_q        <= '0;
            e_q        <= '0;
            bit_done_q <= 1'b0;
            op_q       <= OP_ACC;
            ovf_q      <= 1'b0;
            prod_q     <= '0;
            k_q        <= '0;
            out_q      <= '0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            e_q        <= e_d;
            bit_done_q <= bit_done_d;
            op_q       <= op_d;
            ovf_q      <= ovf_d;
            prod_q     <= prod_d;
            k_q        <= k_d;
            out_q      <= out_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign out_data = out_q;
    assign overflow = ovf_out_q;

endmodule
